// File: rtl/dpd_pkg.sv
// Shared encodings for the DPD feed path: source IDs, scheduler states and Q1.15 sample width.
package dpd_pkg;

  localparam int Q15_WIDTH = 16;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DPD  = 2'd1,
    SRC_CAL  = 2'd2
  } src_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_RUN_DPD = 2'd2,
    ST_RUN_CAL = 2'd3
  } state_t;

  function automatic state_t run_state(input src_t src);
    return (src == SRC_CAL) ? ST_RUN_CAL : ST_RUN_DPD;
  endfunction

endpackage

// File: rtl/interp_feed_sched.sv
// Packet-boundary arbiter feeding the 2x interpolator from the DPD and calibration sources;
// zero-flushes the delay line on every source switch and aborts packets that stall mid-flight.
module interp_feed_sched
  import dpd_pkg::*;
#(
  parameter int DATA_WIDTH = Q15_WIDTH,
  parameter int FLUSH_LEN  = 23,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk_200,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dpd_i,
  input  logic [DATA_WIDTH-1:0] dpd_q,
  input  logic                  dpd_valid,
  input  logic                  dpd_last,
  output logic                  dpd_ready,
  input  logic                  cal_req,
  input  logic [DATA_WIDTH-1:0] cal_i,
  input  logic [DATA_WIDTH-1:0] cal_q,
  input  logic                  cal_valid,
  input  logic                  cal_last,
  output logic                  cal_ready,
  output logic [DATA_WIDTH-1:0] interp_i,
  output logic [DATA_WIDTH-1:0] interp_q,
  output logic                  interp_valid,
  output logic [1:0]            active_src,
  output logic                  flush_busy,
  output logic                  timeout_err
);

  localparam int FCW = $clog2(FLUSH_LEN);
  localparam int GCW = $clog2(TIMEOUT);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_LEN - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(TIMEOUT - 1);

  state_t          state_q, state_d;
  src_t            last_src_q, last_src_d;
  src_t            cand_q, cand_d;
  src_t            active_q, active_d;
  src_t            arb_src;
  logic            fair_q, fair_d;
  logic [FCW-1:0]  flush_cnt_q, flush_cnt_d;
  logic [GCW-1:0]  gap_q, gap_d;
  logic            abort;
  logic            out_vld;
  logic [DATA_WIDTH-1:0] out_i, out_q;

  // Selected view of whichever source owns the current packet
  src_t                  run_src;
  logic                  run_vld;
  logic                  run_last;
  logic [DATA_WIDTH-1:0] run_i, run_q;

  always_comb begin
    run_src  = SRC_DPD;
    run_vld  = dpd_valid;
    run_last = dpd_last;
    run_i    = dpd_i;
    run_q    = dpd_q;
    if (state_q == ST_RUN_CAL) begin
      run_src  = SRC_CAL;
      run_vld  = cal_valid;
      run_last = cal_last;
      run_i    = cal_i;
      run_q    = cal_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_src_d  = last_src_q;
    cand_d      = cand_q;
    active_d    = active_q;
    fair_d      = fair_q;
    flush_cnt_d = flush_cnt_q;
    gap_d       = gap_q;
    arb_src     = SRC_NONE;
    abort       = 1'b0;
    out_vld     = 1'b0;
    out_i       = interp_i;
    out_q       = interp_q;
    dpd_ready   = 1'b0;
    cal_ready   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // fair_dpd only yields to DPD when DPD actually has data waiting
        if (cal_req && !(fair_q && dpd_valid)) begin
          arb_src = SRC_CAL;
        end else if (dpd_valid) begin
          arb_src = SRC_DPD;
        end
        if (arb_src != SRC_NONE) begin
          cand_d = arb_src;
          gap_d  = '0;
          if (arb_src == last_src_q || last_src_q == SRC_NONE) begin
            state_d  = run_state(arb_src);
            active_d = arb_src;
          end else begin
            state_d     = ST_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end

      ST_FLUSH: begin
        out_vld = 1'b1;
        out_i   = '0;
        out_q   = '0;
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d  = run_state(cand_q);
          active_d = cand_q;
        end else begin
          flush_cnt_d = flush_cnt_q + FCW'(1);
        end
      end

      ST_RUN_DPD, ST_RUN_CAL: begin
        dpd_ready = (state_q == ST_RUN_DPD);
        cal_ready = (state_q == ST_RUN_CAL);
        if (run_vld) begin
          out_vld = 1'b1;
          out_i   = run_i;
          out_q   = run_q;
          gap_d   = '0;
          if (run_last) begin
            state_d    = ST_IDLE;
            last_src_d = run_src;
            fair_d     = (run_src == SRC_CAL);
          end
        end else if (gap_q == GAP_LAST) begin
          // Truncated packet: remembering the owner forces a flush on the next switch
          abort      = 1'b1;
          state_d    = ST_IDLE;
          last_src_d = run_src;
          fair_d     = (run_src == SRC_CAL);
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_200 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_src_q   <= SRC_NONE;
      cand_q       <= SRC_NONE;
      active_q     <= SRC_NONE;
      fair_q       <= 1'b0;
      flush_cnt_q  <= '0;
      gap_q        <= '0;
      interp_i     <= '0;
      interp_q     <= '0;
      interp_valid <= 1'b0;
      flush_busy   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_src_q   <= last_src_d;
      cand_q       <= cand_d;
      active_q     <= active_d;
      fair_q       <= fair_d;
      flush_cnt_q  <= flush_cnt_d;
      gap_q        <= gap_d;
      interp_i     <= out_i;
      interp_q     <= out_q;
      interp_valid <= out_vld;
      flush_busy   <= (state_q == ST_FLUSH);
      timeout_err  <= abort;
    end
  end

  assign active_src = active_q;

endmodule
